fs_frame_receiver: RTL and testbench
====================================

Name: fs_frame_receiver

Overview:
Receive end of the Fs send/receive link. It accepts the frame-sync strobe, the slot index, the counter-clear and the serial data strobe from the transmitter. It assembles four WIDTH-bit slots into one frame and returns the ack (per slot) and senack (per frame) handshakes that the transmitter waits on. The completed frame is presented to local logic through a valid/ready port.

Parameters:
WIDTH, 8, bits per slot; serial order is MSB first.
TIMEOUT, 255, maximum idle cycles allowed inside a frame before it is aborted.

Ports:
clk  in  1  system clock; all inputs are synchronous to it.
reset  in  1  asynchronous, active-low reset.
fs  in  1  frame sync from transmitter; a high level starts a frame.
cclear  in  1  slot start from transmitter; clears the bit counter.
bit0  in  1  slot index, LSB.
bit1  in  1  slot index, MSB.
dt  in  1  data strobe; sdata is sampled on every clk where dt=1.
sdata  in  1  serial data bit.
ack  out  1  slot-received handshake to transmitter.
senack  out  1  frame-accepted handshake to transmitter.
rdata  out  4*WIDTH  last good frame; slot 3 occupies the top bits, slot 0 the low bits.
rvalid  out  1  rdata holds an unread frame.
rready  in  1  local consumer takes the frame.
err  out  1  one-cycle pulse on any protocol error or timeout.

Behaviour:
- Reset (async, reset=0): state IDLE; ack, senack, rvalid and err all 0; rdata 0; all counters 0.
- IDLE: ack=0, senack=0. fs=1 → WAIT_SLOT with expected slot=0 and the assembly buffer cleared.
- WAIT_SLOT: dt is ignored.
  - cclear=1 and {bit1,bit0}==expected → SHIFT, bitcnt=0.
  - cclear=1 with a mismatched index → err pulse, → IDLE.
- SHIFT: on each dt=1, buf_slot = {buf_slot[WIDTH-2:0], sdata} and bitcnt increments.
  - On the WIDTH-th strobe → ACK (the slot register is loaded that same edge).
  - cclear=1 in SHIFT restarts the slot (bitcnt=0, slot register cleared) with no error.
- ACK: ack=1 registered, first high the cycle after the last bit. Minimum one cycle.
  - ACK is left on the first cycle with dt=0 and cclear=0.
  - Slot<3 → WAIT_SLOT with expected+1. Slot==3 → DONE.
- DONE: rdata is loaded from the buffer on entry and rvalid=1.
  - rready=1 → rvalid=0 on the next edge, → SENACK.
  - rdata stays stable until the next DONE entry; an aborted frame never alters rdata.
- SENACK: senack=1, minimum one cycle. Stays high until fs=0 is observed, then → IDLE.
- fs=1 in WAIT_SLOT, SHIFT or ACK: err pulse, frame restarted (→ WAIT_SLOT, expected=0, buffer cleared).
  - The fs=1 level in IDLE and SENACK is not an error.
- Timeout: a cycle counter runs in WAIT_SLOT, SHIFT and ACK.
  - It resets on any cclear or dt, and on every state change.
  - Reaching TIMEOUT → err pulse, → IDLE; ack is dropped.
  - DONE and SENACK have no timeout; they wait for the consumer and the transmitter.
- Simultaneous events: fs has priority over cclear; cclear has priority over dt in the same cycle.
- Counter widths: bitcnt is $clog2(WIDTH+1) bits; the timeout counter is $clog2(TIMEOUT+1) bits; no wrap is possible.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package fs_link_pkg:
  - state enum (IDLE, WAIT_SLOT, SHIFT, ACK, DONE, SENACK);
  - NUM_SLOTS=4;
  - slot_idx_t (2-bit);
  - slot index encoding shared with the transmitter.
- One sub-module, fs_slot_shifter: WIDTH shift register plus bit counter, with clear/shift/done ports. The controller FSM, timeout counter and frame buffer stay in the top module.

Test Plan:
- Nominal frame, WIDTH=8: send slots A5,3C,F0,0F with correct indices.
  - ack rises once per slot.
  - rdata=0x0FF03CA5 with rvalid=1; rready pulse → senack=1 until fs drops, then IDLE.
- Wrong slot index: cclear with index 2 while expecting 1 → err single pulse, FSM in IDLE, rdata unchanged from the prior frame.
- Restarts:
  - fs reasserted mid-slot 2 → err pulse, then a full new frame is received correctly.
  - cclear mid-slot → bit count restarts, no err.
- Timeout, TIMEOUT=10: stall dt after 3 bits → err on the 10th idle cycle, ack=0, IDLE.
- Backpressure: hold rready=0 for 50 cycles after DONE → rvalid held, senack=0, rdata stable; no timeout.
- Async reset asserted in SHIFT, and again in ACK with ack=1 → all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fs_link_pkg.sv
`default_nettype none
// ============================================================================
// fs_link_pkg : shared state encoding and slot indexing for the Fs link
// Revision    : 1.0
// ============================================================================
package fs_link_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  localparam slot_idx_t SLOT_FIRST = 2'd0;
  localparam slot_idx_t SLOT_LAST  = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_SLOT = 3'd1;
  localparam state_t ST_SHIFT     = 3'd2;
  localparam state_t ST_ACK       = 3'd3;
  localparam state_t ST_DONE      = 3'd4;
  localparam state_t ST_SENACK    = 3'd5;

  // Slot index as driven by the transmitter on {bit1,bit0}.
  function automatic slot_idx_t slot_index(input logic b1, input logic b0);
    return {b1, b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fs_slot_shifter.sv
`default_nettype none
// ============================================================================
// fs_slot_shifter : MSB-first slot shift register with strobe counter
// Revision        : 1.0
// ============================================================================
module fs_slot_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_sdata,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done
);

  localparam int BW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_data;
  logic [BW-1:0]    r_bitcnt;

  // Asserted on the strobe that completes the slot.
  assign o_done = i_shift && !i_clear && (r_bitcnt == BW'(WIDTH - 1));
  assign o_data = r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_bitcnt <= '0;
    end else if (i_clear) begin
      r_data   <= '0;
      r_bitcnt <= '0;
    end else if (i_shift) begin
      r_data   <= {r_data[WIDTH-2:0], i_sdata};
      r_bitcnt <= r_bitcnt + BW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fs_frame_receiver.sv
`default_nettype none
// ============================================================================
// fs_frame_receiver : Fs link receive end; assembles four slots per frame and
//                     returns ack/senack handshakes to the transmitter
// Revision          : 1.0
// ============================================================================
module fs_frame_receiver
  import fs_link_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs,
  input  logic                       cclear,
  input  logic                       bit0,
  input  logic                       bit1,
  input  logic                       dt,
  input  logic                       sdata,
  output logic                       ack,
  output logic                       senack,
  output logic [NUM_SLOTS*WIDTH-1:0] rdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic                       err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = NUM_SLOTS * WIDTH;
  localparam int BUFW = (NUM_SLOTS - 1) * WIDTH;
  localparam logic [TW-1:0] c_TMAX = TW'(TIMEOUT - 1);

  state_t          r_state;
  slot_idx_t       r_expected;
  logic [BUFW-1:0] r_buf;
  logic [FW-1:0]   r_rdata;
  logic            r_rvalid;
  logic            r_ack;
  logic            r_senack;
  logic            r_err;
  logic [TW-1:0]   r_tcnt;

  state_t          w_next;
  slot_idx_t       w_exp_next;
  logic            w_err;
  logic            w_sh_clear;
  logic            w_sh_shift;
  logic            w_sh_done;
  logic [WIDTH-1:0] w_sh_data;
  logic            w_buf_clear;
  logic            w_slot_wr;
  logic            w_inframe;
  logic            w_timeout;
  logic [FW-1:0]   w_frame;

  fs_slot_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_sh_clear),
    .i_shift (w_sh_shift),
    .i_sdata (sdata),
    .o_data  (w_sh_data),
    .o_done  (w_sh_done)
  );

  assign w_inframe = (r_state == ST_WAIT_SLOT) || (r_state == ST_SHIFT) ||
                     (r_state == ST_ACK);
  assign w_timeout = w_inframe && !fs && !cclear && !dt && (r_tcnt == c_TMAX);
  // Slot 3 is still in the shifter when the frame completes.
  assign w_frame   = {w_sh_data, r_buf};

  always_comb begin
    w_next      = r_state;
    w_exp_next  = r_expected;
    w_err       = 1'b0;
    w_sh_clear  = 1'b0;
    w_sh_shift  = 1'b0;
    w_buf_clear = 1'b0;
    w_slot_wr   = 1'b0;
    if (w_inframe && fs) begin
      w_err       = 1'b1;
      w_next      = ST_WAIT_SLOT;
      w_exp_next  = SLOT_FIRST;
      w_buf_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fs) begin
            w_next      = ST_WAIT_SLOT;
            w_exp_next  = SLOT_FIRST;
            w_buf_clear = 1'b1;
          end
        end
        ST_WAIT_SLOT: begin
          if (cclear) begin
            if (slot_index(bit1, bit0) == r_expected) begin
              w_next     = ST_SHIFT;
              w_sh_clear = 1'b1;
            end else begin
              w_err  = 1'b1;
              w_next = ST_IDLE;
            end
          end else if (w_timeout) begin
            w_err  = 1'b1;
            w_next = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cclear) begin
            w_sh_clear = 1'b1;
          end else if (dt) begin
            w_sh_shift = 1'b1;
            if (w_sh_done) begin
              w_next = ST_ACK;
            end
          end else if (w_timeout) begin
            w_err  = 1'b1;
            w_next = ST_IDLE;
          end
        end
        ST_ACK: begin
          if (!cclear && !dt) begin
            if (r_expected == SLOT_LAST) begin
              w_next = ST_DONE;
            end else begin
              w_slot_wr  = 1'b1;
              w_next     = ST_WAIT_SLOT;
              w_exp_next = r_expected + 2'd1;
            end
          end
        end
        ST_DONE: begin
          if (rready) begin
            w_next = ST_SENACK;
          end
        end
        ST_SENACK: begin
          if (!fs) begin
            w_next = ST_IDLE;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_expected <= SLOT_FIRST;
      r_buf      <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_ack      <= 1'b0;
      r_senack   <= 1'b0;
      r_err      <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      r_state    <= w_next;
      r_expected <= w_exp_next;
      r_ack      <= (w_next == ST_ACK);
      r_senack   <= (w_next == ST_SENACK);
      r_rvalid   <= (w_next == ST_DONE);
      r_err      <= w_err;
      if (w_buf_clear) begin
        r_buf <= '0;
      end else if (w_slot_wr) begin
        r_buf[int'(r_expected)*WIDTH +: WIDTH] <= w_sh_data;
      end
      if (r_state == ST_ACK && w_next == ST_DONE) begin
        r_rdata <= w_frame;
      end
      // Idle counter only advances while nothing happens inside a frame.
      if (!w_inframe || (w_next != r_state) || fs || cclear || dt) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign ack    = r_ack;
  assign senack = r_senack;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fs_frame_receiver.sv
`default_nettype none
// ============================================================================
// tb_fs_frame_receiver : directed/randomized self-checking bench
// Revision             : 1.0
// ============================================================================
module tb_fs_frame_receiver;

  localparam int W  = 8;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fs = 1'b0, cclear = 1'b0, bit0 = 1'b0, bit1 = 1'b0;
  logic dt = 1'b0, sdata = 1'b0, rready = 1'b0;
  logic ack, senack, rvalid, err;
  logic [4*W-1:0] rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_good = '0;

  fs_frame_receiver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fs(fs), .cclear(cclear), .bit0(bit0),
    .bit1(bit1), .dt(dt), .sdata(sdata), .ack(ack), .senack(senack),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_frame();
    return $urandom | 32'h0100_0001;
  endfunction

  task automatic set_idx(input int idx);
    logic [1:0] v;
    v = idx[1:0];
    bit1 = v[1];
    bit0 = v[0];
  endtask

  task automatic fs_pulse();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  // One slot: optional aborted prefix of junk bits restarted by cclear.
  task automatic send_slot(input int idx, input logic [7:0] d, input int junk);
    if (junk > 0) begin
      cclear = 1'b1; set_idx(idx); tick(); cclear = 1'b0;
      for (int i = 0; i < junk; i++) begin
        dt = 1'b1; sdata = 1'($urandom_range(0, 1)); tick();
      end
      dt = 1'b0;
    end
    cclear = 1'b1; set_idx(idx); tick(); cclear = 1'b0;
    if (junk > 0) check("err_on_restart", {63'd0, err}, 64'd0);
    for (int i = W - 1; i >= 0; i--) begin
      dt = 1'b1; sdata = d[i]; tick();
      if (i > 0) check("ack_early", {63'd0, ack}, 64'd0);
    end
    dt = 1'b0;
    check("ack_rise", {63'd0, ack}, 64'd1);
    check("err_slot", {63'd0, err}, 64'd0);
    tick();
    check("ack_fall", {63'd0, ack}, 64'd0);
  endtask

  task automatic full_frame(input logic [31:0] f, input bit do_fs, input int bp, input int jslot);
    if (do_fs) fs_pulse();
    for (int s = 0; s < 4; s++) send_slot(s, f[8*s +: 8], (s == jslot) ? 5 : 0);
    check("rvalid_done", {63'd0, rvalid}, 64'd1);
    check("rdata_done", {32'd0, rdata}, {32'd0, f});
    last_good = f;
    for (int c = 0; c < bp; c++) begin
      tick();
      check("bp_hold", {29'd0, rvalid, senack, err, rdata}, {29'd0, 1'b1, 1'b0, 1'b0, f});
    end
    rready = 1'b1; tick(); rready = 1'b0;
    check("rvalid_taken", {63'd0, rvalid}, 64'd0);
    check("senack_rise", {63'd0, senack}, 64'd1);
    fs = 1'b1; tick();
    check("senack_hold", {62'd0, senack, err}, {62'd0, 1'b1, 1'b0});
    fs = 1'b0; tick();
    check("senack_fall", {63'd0, senack}, 64'd0);
    check("rdata_after", {32'd0, rdata}, {32'd0, last_good});
  endtask

  initial begin
    logic [31:0] f;
    // Reset state
    tick(); tick();
    check("rst_outs", {60'd0, ack, senack, rvalid, err}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    reset = 1'b1;
    tick();

    // Nominal frame and random frames
    full_frame(32'h0FF03CA5, 1'b1, 0, -1);
    for (int n = 0; n < 3; n++) full_frame(rand_frame(), 1'b1, 0, -1);

    // Wrong slot index
    fs_pulse();
    send_slot(0, 8'($urandom), 0);
    cclear = 1'b1; set_idx(2); tick(); cclear = 1'b0;
    check("badidx_err", {63'd0, err}, 64'd1);
    tick();
    check("badidx_pulse", {63'd0, err}, 64'd0);
    check("badidx_rdata", {32'd0, rdata}, {32'd0, last_good});
    check("badidx_rvalid", {63'd0, rvalid}, 64'd0);
    fs_pulse();
    check("badidx_idle", {63'd0, err}, 64'd0);
    full_frame(rand_frame(), 1'b0, 0, -1);

    // fs reasserted mid slot 2
    fs_pulse();
    send_slot(0, 8'($urandom), 0);
    send_slot(1, 8'($urandom), 0);
    cclear = 1'b1; set_idx(2); tick(); cclear = 1'b0;
    for (int i = 0; i < 3; i++) begin dt = 1'b1; sdata = 1'($urandom_range(0, 1)); tick(); end
    dt = 1'b0; fs = 1'b1; tick(); fs = 1'b0;
    check("fsre_err", {63'd0, err}, 64'd1);
    check("fsre_rdata", {32'd0, rdata}, {32'd0, last_good});
    full_frame(rand_frame(), 1'b0, 0, -1);

    // cclear mid-slot restarts the slot silently
    full_frame(rand_frame(), 1'b1, 0, 1);

    // Timeout after 3 bits
    fs_pulse();
    cclear = 1'b1; set_idx(0); tick(); cclear = 1'b0;
    for (int i = 0; i < 3; i++) begin dt = 1'b1; sdata = 1'b1; tick(); end
    dt = 1'b0;
    repeat (TO - 1) tick();
    check("to_early", {63'd0, err}, 64'd0);
    tick();
    check("to_err", {62'd0, err, ack}, {62'd0, 1'b1, 1'b0});
    tick();
    check("to_pulse", {63'd0, err}, 64'd0);
    check("to_rdata", {32'd0, rdata}, {32'd0, last_good});
    fs_pulse();
    check("to_idle", {63'd0, err}, 64'd0);
    full_frame(rand_frame(), 1'b0, 0, -1);

    // Backpressure well beyond the timeout
    full_frame(rand_frame(), 1'b1, 50, -1);

    // Async reset in SHIFT
    fs_pulse();
    cclear = 1'b1; set_idx(0); tick(); cclear = 1'b0;
    for (int i = 0; i < 3; i++) begin dt = 1'b1; sdata = 1'b1; tick(); end
    dt = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_shift", {28'd0, ack, senack, rvalid, err, rdata}, 64'd0);
    last_good = '0;
    #2 reset = 1'b1;

    // Async reset in ACK with ack high
    full_frame(rand_frame(), 1'b1, 0, -1);
    fs_pulse();
    cclear = 1'b1; set_idx(0); tick(); cclear = 1'b0;
    for (int i = 0; i < W; i++) begin dt = 1'b1; sdata = 1'($urandom_range(0, 1)); tick(); end
    dt = 1'b0;
    check("arst_ack_pre", {63'd0, ack}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_ack", {28'd0, ack, senack, rvalid, err, rdata}, 64'd0);
    last_good = '0;
    #2 reset = 1'b1;

    // Recovery after reset
    f = rand_frame();
    full_frame(f, 1'b1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
